vec_scale_q610: RTL and testbench

Consumer at the output end of the Q6.10 reduction path. It takes a scalar, such as a sum or its reciprocal, together with the matching N-element vector delivered alongside it. Each element is multiplied by the scalar, and the block returns the scaled vector with one valid pulse.
The block is time-multiplexed: LANES multipliers are walked across the N elements under a small FSM with a ready/valid input handshake. It sits downstream of the adder tree and its bypass path, for example in normalisation steps.

---
 rtl/q610_pkg.sv | 35 +++
 rtl/mul_q610_lane.sv | 40 ++++
 rtl/vec_scale_q610.sv | 126 ++++++++++++
 tb/tb_vec_scale_q610.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/q610_pkg.sv
// Shared Q6.10 types, constants and the round/saturate helper for the vector scaling path.
package q610_pkg;

    localparam int unsigned Q_W       = 16;
    localparam int unsigned FRAC_BITS = 10;

    typedef logic signed [Q_W-1:0] q610_t;

    localparam q610_t             Q_MAX = 16'sh7FFF;
    localparam q610_t             Q_MIN = 16'sh8000;
    localparam logic signed [31:0] RND  = 32'sd512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Q12.20 product -> Q6.10, round half toward +inf, clamp to the 16-bit range.
    // p is at most 2^30 in magnitude, so adding RND cannot overflow 32 bits.
    function automatic q610_t round_sat_q610(input logic signed [31:0] p);
        logic signed [31:0] r;
        q610_t              res;
        r = (p + RND) >>> FRAC_BITS;
        if (r > 32'sd32767) begin
            res = Q_MAX;
        end else if (r < -32'sd32768) begin
            res = Q_MIN;
        end else begin
            res = $signed(r[Q_W-1:0]);
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_q610_lane.sv
// One Q6.10 multiplier lane: S1 registers the 32-bit product with its element index,
// S2 is the round/saturate result the caller writes into its output slot.
module mul_q610_lane
    import q610_pkg::*;
#(
    parameter int unsigned IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          valid_in,
    input  logic [IW-1:0] idx_in,
    input  q610_t         a,
    input  q610_t         b,
    output logic          valid,
    output logic [IW-1:0] idx,
    output q610_t         res_c
);

    logic signed [31:0] prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= valid_in;
        end
    end

    // Datapath needs no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (en && valid_in) begin
            prod <= 32'(a) * 32'(b);
            idx  <= idx_in;
        end
    end

    assign res_c = round_sat_q610(prod);

endmodule

// File: rtl/vec_scale_q610.sv
// Scales an N-element Q6.10 vector by a latched scalar using LANES time-multiplexed multipliers.
module vec_scale_q610
    import q610_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned LANES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               valid_in,
    output logic               in_ready,
    input  logic [Q_W-1:0]     scalar_in,
    input  logic [N*Q_W-1:0]   vec_in_flat,
    output logic               valid_out,
    output logic [N*Q_W-1:0]   vec_out_flat
);

    localparam int unsigned B  = N / LANES;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned IW = $clog2(N);

    state_t          state;
    logic [BW-1:0]   beat;
    q610_t           scalar_q;
    q610_t           vec_q     [N];
    q610_t           vec_out_q [N];

    logic            accept_c;
    logic            issue_c;
    logic [IW-1:0]   issue_idx  [LANES];
    logic            lane_valid [LANES];
    logic [IW-1:0]   lane_idx   [LANES];
    q610_t           lane_res   [LANES];

    assign accept_c = valid_in && in_ready;
    assign issue_c  = (state == RUN);

    // Control: accept, beat walk, drain and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            beat      <= '0;
            in_ready  <= 1'b1;
            valid_out <= 1'b0;
        end else if (en) begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        state    <= RUN;
                        beat     <= '0;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    beat <= BW'(beat + 1'b1);
                    if (beat == BW'(B - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // S1 holds the final beat here; its S2 write lands on this edge.
                    if (lane_valid[0]) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        valid_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Operand buffers are captured once per job so upstream may change freely afterwards.
    always_ff @(posedge clk) begin
        if (en && accept_c) begin
            scalar_q <= $signed(scalar_in);
            for (int i = 0; i < int'(N); i++) begin
                vec_q[i] <= $signed(vec_in_flat[i*Q_W +: Q_W]);
            end
        end
    end

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign issue_idx[l] = IW'(32'(beat) * LANES + 32'(l));

        mul_q610_lane #(
            .IW (IW)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .valid_in (issue_c),
            .idx_in   (issue_idx[l]),
            .a        (vec_q[issue_idx[l]]),
            .b        (scalar_q),
            .valid    (lane_valid[l]),
            .idx      (lane_idx[l]),
            .res_c    (lane_res[l])
        );
    end

    // S2 stage: each lane writes its rounded result into the slot named by its index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin
                vec_out_q[i] <= '0;
            end
        end else if (en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (lane_valid[l]) begin
                    vec_out_q[lane_idx[l]] <= lane_res[l];
                end
            end
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_out
        assign vec_out_flat[i*Q_W +: Q_W] = vec_out_q[i];
    end

endmodule

// File: tb/tb_vec_scale_q610.sv
// Self-checking bench for vec_scale_q610: fixed vectors, timing corners and random jobs vs. a reference model.
module tb_vec_scale_q610;

    localparam int N = 8;
    localparam int LANES = 2;
    localparam int LAT = 6;

    logic           clk;
    logic           rst;
    logic           en;
    logic           valid_in;
    logic           in_ready;
    logic [15:0]    scalar_in;
    logic [127:0]   vec_in_flat;
    logic           valid_out;
    logic [127:0]   vec_out_flat;

    int checks = 0;
    int failures = 0;

    vec_scale_q610 #(.N(N), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .valid_in     (valid_in),
        .in_ready     (in_ready),
        .scalar_in    (scalar_in),
        .vec_in_flat  (vec_in_flat),
        .valid_out    (valid_out),
        .vec_out_flat (vec_out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [15:0]  scalar;
        logic [127:0] vec;
        logic [127:0] expv;
    } vec_rec_t;

    vec_rec_t tbl [4];
    logic [127:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] pack8(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: exact integer product, floor((p+512)/1024), clamp to int16.
    function automatic logic [127:0] model(input logic [15:0] s, input logic [127:0] v);
        logic [127:0]       o;
        logic signed [15:0] e;
        logic signed [15:0] sc;
        int p, q, r;
        sc = s;
        o = '0;
        for (int i = 0; i < N; i++) begin
            e = v[i*16 +: 16];
            p = int'(e) * int'(sc);
            q = p + 512;
            if (q >= 0) r = q / 1024;
            else        r = -((-q + 1023) / 1024);
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            o[i*16 +: 16] = 16'(r);
        end
        return o;
    endfunction

    // One job from an idle block; optional en stall mid-RUN and optional stall while valid_out is high.
    task automatic run_job(input string name, input logic [15:0] s, input logic [127:0] v,
                           input logic [127:0] expv, input int stall_at, input int exp_lat, input bit hold);
        int lat;
        logic [127:0] held;
        check({name, "_in_ready"}, 128'(in_ready), 128'(1));
        scalar_in   = s;
        vec_in_flat = v;
        valid_in    = 1'b1;
        tick();
        valid_in    = 1'b0;
        scalar_in   = 16'($urandom);
        vec_in_flat = rand128();
        lat = 1;
        while (!valid_out && lat < 40) begin
            en = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 3);
            tick();
            lat++;
        end
        en = 1'b1;
        check({name, "_latency"}, 128'(lat), 128'(exp_lat));
        check({name, "_data"}, vec_out_flat, expv);
        check({name, "_ready_at_pulse"}, 128'(in_ready), 128'(1));
        if (hold) begin
            held = vec_out_flat;
            en = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                check({name, "_pulse_held"}, 128'(valid_out), 128'(1));
            end
            check({name, "_data_held"}, vec_out_flat, held);
            en = 1'b1;
        end
        tick();
        check({name, "_pulse_width"}, 128'(valid_out), 128'(0));
        check({name, "_data_kept"}, vec_out_flat, expv);
    endtask

    initial begin
        int last_vo;
        int nres;
        int seen;
        logic [15:0]  rs;
        logic [127:0] rv;

        rst = 1'b1; en = 1'b0; valid_in = 1'b0; scalar_in = '0; vec_in_flat = '0;

        tbl[0] = '{"identity", 16'h0400,
            pack8(16'h0A00, 16'hFC00, 16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000),
            pack8(16'h0A00, 16'hFC00, 16'h0001, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000)};
        tbl[1] = '{"saturate", 16'h1000,
            pack8(16'h4000, 16'hC000, 16'h0200, 16'h0001, 16'hFFFF, 16'h1FFF, 16'h2000, 16'hE000),
            pack8(16'h7FFF, 16'h8000, 16'h0800, 16'h0004, 16'hFFFC, 16'h7FFC, 16'h7FFF, 16'h8000)};
        tbl[2] = '{"round_half", 16'h0200,
            pack8(16'h0001, 16'hFFFF, 16'h0003, 16'h0002, 16'hFFFE, 16'hFFFD, 16'h7FFF, 16'h8000),
            pack8(16'h0001, 16'h0000, 16'h0002, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h4000, 16'hC000)};
        tbl[3] = '{"round_1ff", 16'h01FF,
            pack8(16'h0001, 16'h0002, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0400, 16'hFC00, 16'h0000),
            pack8(16'h0000, 16'h0001, 16'h3FE0, 16'hC020, 16'h0000, 16'h01FF, 16'hFE01, 16'h0000)};

        // Reset wins over en low.
        tick();
        tick();
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_valid_out", 128'(valid_out), 128'(0));
        check("reset_vec_out", vec_out_flat, 128'(0));
        rst = 1'b0;
        en  = 1'b1;
        tick();

        foreach (tbl[i]) begin
            run_job(tbl[i].name, tbl[i].scalar, tbl[i].vec, tbl[i].expv, 0, LAT, 1'b0);
        end

        // en stall mid-RUN lengthens latency by exactly 3; then a stall across the pulse.
        run_job("stall_run", tbl[1].scalar, tbl[1].vec, tbl[1].expv, 2, LAT + 3, 1'b0);
        run_job("stall_pulse", tbl[2].scalar, tbl[2].vec, tbl[2].expv, 0, LAT, 1'b1);

        // valid_in held high with inputs changing every cycle.
        exp_q.delete();
        last_vo = -1;
        nres = 0;
        valid_in = 1'b1;
        for (int c = 0; c < 40; c++) begin
            scalar_in   = 16'($urandom);
            vec_in_flat = rand128();
            if (in_ready) exp_q.push_back(model(scalar_in, vec_in_flat));
            tick();
            if (valid_out) begin
                if (exp_q.size() == 0) check("b2b_unexpected", 128'(1), 128'(0));
                else                   check("b2b_data", vec_out_flat, exp_q.pop_front());
                if (last_vo >= 0) check("b2b_period", 128'(c - last_vo), 128'(LAT));
                last_vo = c;
                nres++;
            end
        end
        valid_in = 1'b0;
        check("b2b_count", 128'(nres), 128'(6));
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            if (valid_out) check("b2b_tail", vec_out_flat, exp_q.pop_front());
        end
        check("b2b_drained", 128'(exp_q.size()), 128'(0));
        tick();

        // Reset at beat 2 aborts the job.
        scalar_in = tbl[0].scalar; vec_in_flat = tbl[0].vec; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_vec_out", vec_out_flat, 128'(0));
        check("abort_valid_out", 128'(valid_out), 128'(0));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid_out) seen++;
        end
        check("abort_no_pulse", 128'(seen), 128'(0));
        run_job("after_abort", tbl[3].scalar, tbl[3].vec, tbl[3].expv, 0, LAT, 1'b0);

        // Random jobs against the reference model.
        for (int j = 0; j < 10; j++) begin
            rs = 16'($urandom);
            if (j % 3 == 0) rs = 16'($urandom_range(0, 2047));
            rv = rand128();
            run_job("random", rs, rv, model(rs, rv), (j == 4) ? 3 : 0, (j == 4) ? LAT + 3 : LAT, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
